// File: rtl/fft_cont_mc_pkg.sv
// Shared encodings for the multi-channel FFT controller: commands, config_valid
// codes, per-channel state and setting-word field positions.
package fft_cont_mc_pkg;

  localparam logic [31:0] CMD_START     = 32'd1;
  localparam logic [31:0] CMD_SOFT_STOP = 32'd2;
  localparam logic [31:0] CMD_ABORT     = 32'd3;
  localparam logic [31:0] CMD_CLR_ERR   = 32'd4;

  localparam logic [1:0] CV_CFG = 2'd1;
  localparam logic [1:0] CV_CMD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int IFFT_BIT  = 31;
  localparam int POINT_MSB = 30;
  localparam int POINT_LSB = 27;
  localparam int FSH_MSB   = 26;
  localparam int FSH_LSB   = 22;
  localparam int SCL_MSB   = 21;
  localparam int SCL_LSB   = 4;

endpackage

// File: rtl/fft_cont_mc_ch.sv
// One FFT channel controller: run state, in-flight packet count, sticky errors,
// setting register, registered input gate and abort flush pulse.
module fft_cont_ch
  import fft_cont_mc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int SLACK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic        cmd_vld,
  input  logic [31:0] cmd,
  input  logic [31:0] cfg_word,
  input  logic        rx,
  input  logic        tx,
  output logic        is_ready,
  output logic        flush,
  output logic        ifft,
  output logic [3:0]  point,
  output logic [4:0]  final_shift,
  output logic [17:0] scaling,
  output logic [3:0]  status
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_LIM = CW'(DEPTH - SLACK);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   setting;
  logic          ovf_err, udf_err;
  logic          do_start, do_stop, do_abort, do_clr;
  logic          inc, dec, ovf_evt, udf_evt;

  // Abort only applies to an active channel; in that cycle rx/tx are discarded.
  always_comb begin
    do_start  = cmd_vld && (cmd == CMD_START);
    do_stop   = cmd_vld && (cmd == CMD_SOFT_STOP);
    do_abort  = cmd_vld && (cmd == CMD_ABORT) && (state != ST_IDLE);
    do_clr    = cmd_vld && (cmd == CMD_CLR_ERR);
    inc       = rx && !tx;
    dec       = tx && !rx;
    ovf_evt   = !do_abort && inc && (count == CNT_MAX);
    udf_evt   = !do_abort && dec && (count == '0);
    count_nxt = count;
    if (do_abort)                       count_nxt = '0;
    else if (inc && count != CNT_MAX)   count_nxt = count + CW'(1);
    else if (dec && count != '0)        count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (do_start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (do_abort)     state_nxt = ST_IDLE;
        else if (do_stop) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (do_abort || count == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      setting  <= '0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
      is_ready <= 1'b0;
      flush    <= 1'b0;
    end else begin
      count    <= count_nxt;
      if (cfg_wr && state == ST_IDLE) setting <= cfg_word;
      // A fresh error event beats a same-cycle clear.
      ovf_err  <= ovf_evt || (ovf_err && !do_clr);
      udf_err  <= udf_evt || (udf_err && !do_clr);
      is_ready <= !do_abort && (state == ST_RUN) && (count_nxt < RDY_LIM);
      flush    <= do_abort;
    end
  end

  always_comb begin
    status      = {ovf_err, udf_err, state == ST_DRAIN, state == ST_IDLE};
    ifft        = setting[IFFT_BIT];
    point       = setting[POINT_MSB:POINT_LSB];
    final_shift = setting[FSH_MSB:FSH_LSB];
    scaling     = setting[SCL_MSB:SCL_LSB];
  end

endmodule

// File: rtl/fft_cont_mc.sv
// Multi-channel FFT controller top: decodes cfg_ch / config_valid and fans out
// to NCH independent channel controllers.
module fft_cont_mc
  import fft_cont_mc_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int DEPTH = 1024,
  parameter  int SLACK = 2,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [1:0]        config_valid,
  input  logic [31:0]       input_config,
  input  logic [31:0]       input_command,
  input  logic [NCH-1:0]    rx_valid,
  input  logic [NCH-1:0]    tx_valid,
  output logic [NCH-1:0]    is_ready,
  output logic [NCH-1:0]    flush,
  output logic [NCH-1:0]    ifft,
  output logic [NCH*4-1:0]  point,
  output logic [NCH*5-1:0]  final_shift,
  output logic [NCH*18-1:0] scaling,
  output logic [NCH*4-1:0]  status
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = (cfg_ch == CHW'(i));

    fft_cont_ch #(.DEPTH(DEPTH), .SLACK(SLACK)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (sel && config_valid == CV_CFG),
      .cmd_vld     (sel && config_valid == CV_CMD),
      .cmd         (input_command),
      .cfg_word    (input_config),
      .rx          (rx_valid[i]),
      .tx          (tx_valid[i]),
      .is_ready    (is_ready[i]),
      .flush       (flush[i]),
      .ifft        (ifft[i]),
      .point       (point[i*4 +: 4]),
      .final_shift (final_shift[i*5 +: 5]),
      .scaling     (scaling[i*18 +: 18]),
      .status      (status[i*4 +: 4])
    );
  end

endmodule

// File: tb/tb_fft_cont_mc.sv
// Scoreboard bench for fft_cont_mc: directed scenarios plus random traffic,
// every cycle's outputs compared against a behavioural channel model.
module tb_fft_cont_mc;
  localparam int NCH = 2, DEPTH = 1024, SLACK = 2, CHW = 1;

  logic              clk = 0, rst = 1;
  logic [CHW-1:0]    cfg_ch = '0;
  logic [1:0]        config_valid = '0;
  logic [31:0]       input_config = '0, input_command = '0;
  logic [NCH-1:0]    rx_valid = '0, tx_valid = '0;
  logic [NCH-1:0]    is_ready, flush, ifft;
  logic [NCH*4-1:0]  point, status;
  logic [NCH*5-1:0]  final_shift;
  logic [NCH*18-1:0] scaling;

  fft_cont_mc #(.NCH(NCH), .DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk), .rst(rst), .cfg_ch(cfg_ch), .config_valid(config_valid),
    .input_config(input_config), .input_command(input_command),
    .rx_valid(rx_valid), .tx_valid(tx_valid), .is_ready(is_ready), .flush(flush),
    .ifft(ifft), .point(point), .final_shift(final_shift), .scaling(scaling),
    .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    logic [NCH-1:0]    rdy, fl, ifft;
    logic [NCH*4-1:0]  point, status;
    logic [NCH*5-1:0]  fs;
    logic [NCH*18-1:0] sc;
  } exp_t;
  exp_t sb[$];

  // Behavioural model: state 0 idle, 1 run, 2 drain.
  int          m_st[NCH], m_cnt[NCH];
  bit          m_rdy[NCH], m_fl[NCH], m_ovf[NCH], m_udf[NCH];
  logic [31:0] m_set[NCH];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic model_step(input bit r, input logic [1:0] cv, input int ch,
                            input logic [31:0] cfg, input logic [31:0] cmd,
                            input logic [NCH-1:0] rxv, input logic [NCH-1:0] txv);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_st[i] = 0; m_cnt[i] = 0; m_rdy[i] = 0; m_fl[i] = 0;
        m_ovf[i] = 0; m_udf[i] = 0; m_set[i] = '0;
      end else begin
        bit here, abort_c, ovf_e, udf_e, clr;
        int st_n, cnt_n;
        here    = (cv == 2'd2) && (ch == i);
        abort_c = here && cmd == 3 && m_st[i] != 0;
        clr     = here && cmd == 4;
        st_n = m_st[i];
        cnt_n = m_cnt[i];
        ovf_e = 0; udf_e = 0;
        if (abort_c) begin
          st_n = 0; cnt_n = 0;
        end else begin
          if (rxv[i] && !txv[i]) begin
            if (m_cnt[i] == DEPTH) ovf_e = 1; else cnt_n = m_cnt[i] + 1;
          end
          if (txv[i] && !rxv[i]) begin
            if (m_cnt[i] == 0) udf_e = 1; else cnt_n = m_cnt[i] - 1;
          end
          if (m_st[i] == 0 && here && cmd == 1) st_n = 1;
          if (m_st[i] == 1 && here && cmd == 2) st_n = 2;
          if (m_st[i] == 2 && m_cnt[i] == 0)    st_n = 0;
        end
        m_rdy[i] = !abort_c && m_st[i] == 1 && cnt_n < DEPTH - SLACK;
        m_fl[i]  = abort_c;
        m_ovf[i] = ovf_e || (m_ovf[i] && !clr);
        m_udf[i] = udf_e || (m_udf[i] && !clr);
        if (cv == 2'd1 && ch == i && m_st[i] == 0) m_set[i] = cfg;
        m_st[i]  = st_n;
        m_cnt[i] = cnt_n;
      end
    end
  endtask

  task automatic drive(input bit r, input logic [1:0] cv, input int ch,
                       input logic [31:0] cfg, input logic [31:0] cmd,
                       input logic [NCH-1:0] rxv, input logic [NCH-1:0] txv);
    exp_t e;
    @(posedge clk); #1;
    rst = r; config_valid = cv; cfg_ch = ch[CHW-1:0];
    input_config = cfg; input_command = cmd; rx_valid = rxv; tx_valid = txv;
    model_step(r, cv, ch, cfg, cmd, rxv, txv);
    e.due = cyc + 1;
    for (int i = 0; i < NCH; i++) begin
      e.rdy[i]          = m_rdy[i];
      e.fl[i]           = m_fl[i];
      e.ifft[i]         = m_set[i][31];
      e.point[i*4 +: 4] = m_set[i][30:27];
      e.fs[i*5 +: 5]    = m_set[i][26:22];
      e.sc[i*18 +: 18]  = m_set[i][21:4];
      e.status[i*4 +: 4] = {m_ovf[i], m_udf[i], m_st[i] == 2, m_st[i] == 0};
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 2'd0, 0, '0, '0, '0, '0);
  endtask

  task automatic cmd_to(input int ch, input logic [31:0] c);
    drive(0, 2'd2, ch, '0, c, '0, '0);
  endtask

  task automatic pulses(input int n, input logic [NCH-1:0] rxv, input logic [NCH-1:0] txv);
    for (int k = 0; k < n; k++) drive(0, 2'd0, 0, '0, '0, rxv, txv);
  endtask

  // Monitor: compares every expected entry in the cycle it falls due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("is_ready",    64'(is_ready),    64'(e.rdy));
        chk("flush",       64'(flush),       64'(e.fl));
        chk("status",      64'(status),      64'(e.status));
        chk("ifft",        64'(ifft),        64'(e.ifft));
        chk("point",       64'(point),       64'(e.point));
        chk("final_shift", 64'(final_shift), 64'(e.fs));
        chk("scaling",     64'(scaling),     64'(e.sc));
      end
    end
  end

  initial begin
    drive(1, 2'd0, 0, '0, '0, '0, '0);
    drive(1, 2'd0, 0, '0, '0, 2'b11, 2'b01);
    idle(2);
    // ch0: configure, start, check setting fields and ready latency
    drive(0, 2'd1, 0, 32'h8800_0010, '0, '0, '0);
    cmd_to(0, 1);
    idle(3);
    // ch1: fill to the ready threshold, then to DEPTH, then overflow
    cmd_to(1, 1);
    pulses(DEPTH - SLACK, 2'b10, 2'b00);
    idle(1);
    pulses(2, 2'b10, 2'b00);
    idle(1);
    pulses(1, 2'b10, 2'b00);
    idle(1);
    cmd_to(1, 4);
    // ch1: abort, restart, soft stop with 3 in flight, drain
    cmd_to(1, 3);
    cmd_to(1, 1);
    pulses(3, 2'b10, 2'b00);
    cmd_to(1, 2);
    pulses(3, 2'b00, 2'b10);
    idle(3);
    // ch0: 50 in flight, abort with same-cycle rx
    pulses(50, 2'b01, 2'b00);
    drive(0, 2'd2, 0, '0, 32'd3, 2'b01, 2'b00);
    idle(2);
    // ch0: underflow, clear, config write during RUN dropped
    pulses(1, 2'b00, 2'b01);
    cmd_to(0, 4);
    drive(0, 2'd2, 0, '0, 32'd4, 2'b00, 2'b01);
    cmd_to(0, 4);
    cmd_to(0, 1);
    drive(0, 2'd1, 0, 32'h1234_5678, '0, '0, '0);
    idle(2);
    // mid-RUN reset with traffic and a command
    pulses(4, 2'b11, 2'b00);
    drive(1, 2'd2, 1, '0, 32'd2, 2'b01, 2'b10);
    idle(2);
    // random traffic
    for (int k = 0; k < 4000; k++) begin
      int r;
      logic [1:0] cv;
      r  = $urandom_range(0, 15);
      cv = (r < 2) ? 2'd1 : (r < 4) ? 2'd2 : (r == 4) ? 2'd3 : 2'd0;
      drive($urandom_range(0, 799) == 0, cv, $urandom_range(0, NCH - 1), $urandom,
            32'($urandom_range(0, 5)), NCH'($urandom), NCH'($urandom));
    end
    idle(2);
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_cont_mc.md
FFT_CONT_MC -- requirements
Module: fft_cont_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of independent FFT channels (1..8).
REQ-002 The block SHALL have parameter DEPTH, default 1024, per-channel in-flight packet capacity.
REQ-003 The block SHALL have parameter SLACK, default 2, headroom below DEPTH at which is_ready drops.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port cfg_ch, input, CHW=max(1,$clog2(NCH)), which channel a config write or command targets.
REQ-007 The block SHALL have port config_valid, input, 2: 1 = config write, 2 = command, 0/3 = no-op.
REQ-008 The block SHALL have port input_config, input, 32, the setting word.
REQ-009 The block SHALL have port input_command, input, 32: 1 start, 2 soft stop, 3 abort, 4 clear errors, others ignored.
REQ-010 The block SHALL have port rx_valid, input, NCH, one packet entered channel i's datapath this cycle.
REQ-011 The block SHALL have port tx_valid, input, NCH, one packet left channel i's datapath this cycle.
REQ-012 The block SHALL have port is_ready, output, NCH, registered input gate per channel.
REQ-013 The block SHALL have port flush, output, NCH, one-cycle datapath flush pulse per channel.
REQ-014 The block SHALL have ports ifft (NCH x1), point (NCH x4), final_shift (NCH x5) and scaling (NCH x18), all outputs, per-channel setting fields.
REQ-015 The block SHALL have port status, output, NCH x4, per channel {ovf_err, udf_err, draining, idle}.

Function
REQ-016 Setting word layout: [31] ifft, [30:27] point, [26:22] final_shift, [21:4] scaling; [3:0] stored but unused.
REQ-017 A config write SHALL update setting[cfg_ch] the next cycle only when that channel is IDLE; otherwise it SHALL be dropped silently.
REQ-018 Per-channel state: IDLE(0), RUN(1), DRAIN(2).
REQ-019 Transitions: IDLE->RUN on start; RUN->DRAIN on soft stop; DRAIN->IDLE in the cycle after count==0 is observed; RUN/DRAIN->IDLE on abort.
REQ-020 Commands not valid for the current state SHALL be ignored; only channel cfg_ch is affected.
REQ-021 Per-channel occupancy count SHALL be width $clog2(DEPTH+1): +1 on rx only, -1 on tx only, unchanged on both or neither.
REQ-022 A tx pulse at count==0 SHALL hold the count at 0 and set udf_err.
REQ-023 An rx pulse at count==DEPTH SHALL hold the count at DEPTH and set ovf_err.
REQ-024 is_ready[i] SHALL be registered; its next value = (state==RUN) && (count_next < DEPTH-SLACK), i.e. 1-cycle latency from state/count change.
REQ-025 Abort SHALL pulse flush[i] for exactly one cycle (the cycle after the command), zero count[i], and drop is_ready[i] the same cycle; rx/tx pulses in the abort cycle SHALL be discarded.
REQ-026 Clear errors SHALL zero both sticky error bits of cfg_ch in any state; a same-cycle new error event SHALL win (bit stays set).
REQ-027 status idle/draining SHALL be combinational decodes of registered state; setting-field outputs SHALL be direct from setting registers.
REQ-028 Channels SHALL be fully independent; simultaneous rx/tx on different channels SHALL not interact.

Reset
REQ-029 On rst, all states SHALL be IDLE, counts 0, settings 0, error bits 0, is_ready 0, flush 0.
REQ-030 rst asserted mid-operation SHALL override all commands and counter events in that cycle.

Structure
REQ-031 The shared package SHALL hold the command encodings, the config_valid encodings, the state enum, and the setting-field bit positions.
REQ-032 A per-channel sub-module fft_cont_ch (state, count, errors, setting, is_ready, flush) SHALL be instantiated NCH times via generate; the top decodes cfg_ch.

Verification
REQ-033 Scenario: cfg write ch0 0x8800_0010 in IDLE, start -> ifft[0]=1, point[0]=1, scaling[0]=1; is_ready[0]=1 two cycles after start.
REQ-034 Scenario: RUN, 1022 rx on ch1 (DEPTH 1024, SLACK 2) -> is_ready[1]=0 the cycle after the 1022nd rx; 2 more rx -> count 1024, no ovf; 1 more -> ovf_err=1.
REQ-035 Scenario: soft stop with count 3, then 3 tx -> draining=1 until the cycle after count hits 0, then idle=1.
REQ-036 Scenario: abort ch0 in RUN with count 50 plus same-cycle rx -> flush[0] pulses once, count 0, idle, no ovf.
REQ-037 Scenario: tx at count 0 -> udf_err; clear-errors -> 0; config write during RUN -> setting unchanged.
REQ-038 Scenario: rst asserted mid-RUN with rx/tx active -> all outputs at their reset values the next cycle.
